seg7_scan_capture: RTL and testbench
====================================

# seg7_scan_capture

Receiving end of the multiplexed seven-segment bus (`SevenSegment`/`Enable`) that the `led` display driver produces on the Elbert V2. It samples the scanned bus, decodes each active-low segment pattern back to a hex nibble, and assembles a complete 3-digit frame once every digit has been seen stable. It serves as a synthesizable loopback monitor for on-board self-test and as the checking element in display benches.

## Interface
Parameters:
- `STABLE_CYCLES`, 4: consecutive identical registered samples (same enable) required to accept a digit; legal range 1–255.
- `TIMEOUT_CYCLES`, 65536: cycles without a completed frame before `Stale` asserts; ≥ 2.

Ports:
- `Clk` in 1: single clock; all logic rising-edge.
- `Rst` in 1: synchronous, active-low reset.
- `SevenSegment` in 8: active-low segments. Bit mapping: [0]=a … [6]=g, [7]=dp.
- `Enable` in 3: active-low digit enables; [0] is the rightmost digit.
- `Digits` out 12: last complete frame, nibble i = digit i.
- `Dp` out 3: decimal-point state per digit, 1 = lit.
- `DigitErr` out 3: per digit, 1 = accepted pattern was not a legal hex glyph.
- `FrameValid` out 1: one-cycle pulse when `Digits`/`Dp`/`DigitErr` update.
- `MultiEnErr` out 1: one-cycle pulse when more than one enable is low.
- `Stale` out 1: level; no frame completed within `TIMEOUT_CYCLES`.

## Operation
- Input register: `SevenSegment`/`Enable` captured every cycle. All decisions use registered values.
- Decode (active-high gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. Any other pattern, including blank (00), gives nibble 0 with the error flag set.
- Tracker FSM:
  - IDLE: no enable low. Move to TRACK when exactly one enable is low; load the stable count with 1.
  - TRACK: if the enable and all 8 segment bits equal the previous sample, increment the count; otherwise reload 1 and stay in TRACK. When the count reaches `STABLE_CYCLES`, accept and go to LOCKED.
  - LOCKED: ignore samples until the enable changes. A change to another single enable goes to TRACK; all enables high goes to IDLE.
- Accept: write nibble, dp and err for digit i into the shadow registers; set `seen[i]`. A repeat accept of the same digit within a frame overwrites the shadow (newest wins).
- Frame: when `seen` becomes 3'b111, copy shadow to the outputs, pulse `FrameValid`, and clear `seen`.
- Multi-enable: more than one enable low pulses `MultiEnErr` and forces IDLE. The `seen` mask and shadow registers are kept.
- Timeout: counter cleared on `FrameValid` and saturates at `TIMEOUT_CYCLES`. `Stale` = (counter == `TIMEOUT_CYCLES`); `Stale` clears on the next `FrameValid`.

## Timing
- Reset values: `Digits`=0, `Dp`=0, `DigitErr`=0, `FrameValid`=0, `MultiEnErr`=0, `Stale`=0. Internally: FSM in IDLE, `seen`=0, shadow=0, counters=0.
- Reset asserted mid-operation clears everything on that edge. Partial frames are discarded.
- Latency: a bus value presented before edge E is registered at E and accepted at edge E+`STABLE_CYCLES`. If that accept completes a frame, outputs and `FrameValid` update at edge E+`STABLE_CYCLES`+1.
- `MultiEnErr` is high for the cycle after the offending registered sample.
- A glitch of one cycle inside TRACK restarts the count, so the accept is delayed by the full `STABLE_CYCLES`.
- Simultaneous accept and timeout saturation: `FrameValid` wins, and the counter clears.

## Structure
- Package `seg7_pkg` holds:
  - `NUM_DIGITS`=3;
  - the 16 glyph constants;
  - the segment bit-index constants;
  - the tracker state enum (IDLE/TRACK/LOCKED).
- Sub-module `seg7_pattern_decode`: combinational, 7-bit active-high pattern in, nibble and error out. One instance is shared by the tracker.
- Top `seg7_scan_capture`: input register, FSM, shadow and frame logic, timeout counter.

## Test plan
- Clean scan: display "1A7" (digit2=1, digit1=A, digit0=7), each enable held 8 cycles in round-robin, dp off. Required: `FrameValid` pulses once per full scan, `Digits`=12'h1A7, `Dp`=0, `DigitErr`=0.
- Glitch: during digit0, `SevenSegment` changes for 1 cycle after 2 stable cycles, then holds 8 cycles. Required: accept delayed 3 cycles; value = final pattern.
- Illegal glyph: digit1 driven with pattern 0x49, dp lit. Required: `DigitErr`=3'b010, `Digits[7:4]`=0, `Dp[1]`=1.
- Ghosting: `Enable`=3'b100 (two digits low) for 1 cycle mid-scan. Required: one `MultiEnErr` pulse; frame still completes on the next valid scan with correct `Digits`.
- Timeout: `TIMEOUT_CYCLES`=100, all enables held high. Required: `Stale`=1 from cycle 100 onward; a subsequent full clean scan clears it with `FrameValid`.
- Reset mid-frame: after digits 0 and 1 are accepted, pulse `Rst` low for 1 cycle, then scan digit2 only. Required: no `FrameValid`; outputs remain 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment scan capture block.
//   NUM_DIGITS     number of multiplexed digits on the bus
//   GLYPH_*        active-high gfedcba patterns for hex 0..F
//   SEG_*          bit positions of each segment on the SevenSegment bus
//   track_state_t  per-digit stability tracker states
package seg7_pkg;

  localparam int NUM_DIGITS = 3;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } track_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational seven-segment glyph to hex decoder.
//   pattern  in  7  active-high segments, gfedcba
//   nibble   out 4  decoded hex value (0 when the pattern is not a glyph)
//   err      out 1  pattern is not one of the 16 hex glyphs (blank included)
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       err
);

  always_comb begin
    nibble = 4'h0;
    err    = 1'b0;
    case (pattern)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: receives a multiplexed seven-segment bus, decodes each
// digit once it has been stable, and publishes complete 3-digit frames.
//   Clk           in  1   rising-edge clock
//   Rst           in  1   synchronous active-low reset
//   SevenSegment  in  8   active-low segments, [6:0]=gfedcba, [7]=dp
//   Enable        in  3   active-low digit enables, [0] = rightmost digit
//   Digits        out 12  last complete frame, nibble i = digit i
//   Dp            out 3   decimal point per digit, 1 = lit
//   DigitErr      out 3   per digit, accepted pattern was not a hex glyph
//   FrameValid    out 1   one-cycle pulse when Digits/Dp/DigitErr update
//   MultiEnErr    out 1   one-cycle pulse after a sample with >1 enable low
//   Stale         out 1   no frame completed within TIMEOUT_CYCLES
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [7:0]  SevenSegment,
  input  logic [2:0]  Enable,
  output logic [11:0] Digits,
  output logic [2:0]  Dp,
  output logic [2:0]  DigitErr,
  output logic        FrameValid,
  output logic        MultiEnErr,
  output logic        Stale
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [7:0]      seg_p0, seg_p1;
  logic [2:0]      en_p0, en_p1;
  track_state_t    state, state_nxt;
  logic [7:0]      cnt, cnt_nxt;
  logic            accept;
  logic [2:0]      sel;
  logic            single, none, multi, same;
  logic [3:0]      dec_nib;
  logic            dec_err;
  logic [11:0]     sh_nib;
  logic [2:0]      sh_dp, sh_err, seen;
  logic            frame;
  logic [TW-1:0]   tcnt;

  // stage p0: registered bus sample; p1: the sample before it
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      seg_p0 <= 8'hFF;
      en_p0  <= 3'b111;
      seg_p1 <= 8'hFF;
      en_p1  <= 3'b111;
    end else begin
      seg_p0 <= SevenSegment;
      en_p0  <= Enable;
      seg_p1 <= seg_p0;
      en_p1  <= en_p0;
    end
  end

  assign sel    = ~en_p0;
  assign single = $onehot(sel);
  assign none   = (sel == 3'b000);
  assign multi  = !single && !none;
  assign same   = (seg_p0 == seg_p1) && (en_p0 == en_p1);

  seg7_pattern_decode u_decode (
    .pattern (~seg_p0[SEG_G:SEG_A]),
    .nibble  (dec_nib),
    .err     (dec_err)
  );

  // tracker: stability counting on the p0 sample
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    if (multi) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (single) begin
            state_nxt = TRACK;
            cnt_nxt   = 8'd1;
          end
        end
        TRACK: begin
          if (none)      state_nxt = IDLE;
          else if (same) cnt_nxt   = cnt + 8'd1;
          else           cnt_nxt   = 8'd1;
        end
        LOCKED: begin
          if (none) begin
            state_nxt = IDLE;
          end else if (en_p0 != en_p1) begin
            state_nxt = TRACK;
            cnt_nxt   = 8'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    // A fresh count of 1 can already satisfy STABLE_CYCLES == 1.
    if (state_nxt == TRACK && cnt_nxt == 8'(STABLE_CYCLES)) begin
      accept    = 1'b1;
      state_nxt = LOCKED;
    end
  end

  assign frame = (seen == 3'b111);

  // shadow/frame stage: accepted digits collect here until all are seen
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      sh_nib     <= '0;
      sh_dp      <= '0;
      sh_err     <= '0;
      seen       <= '0;
      Digits     <= '0;
      Dp         <= '0;
      DigitErr   <= '0;
      FrameValid <= 1'b0;
      MultiEnErr <= 1'b0;
      tcnt       <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (accept && sel[i]) begin
          sh_nib[i*4 +: 4] <= dec_nib;
          sh_dp[i]         <= ~seg_p0[SEG_DP];
          sh_err[i]        <= dec_err;
        end
      end
      // A frame copy and a new accept may land on the same edge; the new
      // digit then starts the next frame's mask.
      seen       <= (frame ? 3'b000 : seen) | (accept ? sel : 3'b000);
      FrameValid <= frame;
      MultiEnErr <= multi;
      if (frame) begin
        Digits   <= sh_nib;
        Dp       <= sh_dp;
        DigitErr <= sh_err;
      end
      if (frame)                              tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT_CYCLES))   tcnt <= tcnt + TW'(1);
    end
  end

  assign Stale = (tcnt == TW'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_seg7_scan_capture.sv
module tb_seg7_scan_capture;

  localparam int S = 4;
  localparam int T = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  seg = 8'hFF;
  logic [2:0]  en = 3'b111;
  logic [11:0] digits;
  logic [2:0]  dp, derr;
  logic        fv, mee, stale;

  seg7_scan_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .Clk          (clk),
    .Rst          (rst_n),
    .SevenSegment (seg),
    .Enable       (en),
    .Digits       (digits),
    .Dp           (dp),
    .DigitErr     (derr),
    .FrameValid   (fv),
    .MultiEnErr   (mee),
    .Stale        (stale)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Expected output events, keyed by the clock edge at which they take effect.
  typedef struct {
    int         e;
    bit         is_rst;
    logic [11:0] d;
    logic [2:0]  p;
    logic [2:0]  r;
  } ev_t;
  ev_t eq[$];
  int  mq[$];

  // Reference model state: a "dwell" is an unbroken run of samples with the
  // same single enable; it yields at most one accepted digit, at the first
  // point where its last S samples are identical.
  bit          dwell_on = 0;
  logic [2:0]  dwell_en = 3'b111;
  logic [7:0]  run_seg = 8'hFF;
  int          run_len = 0;
  bit          accepted = 0;
  logic [11:0] sh_d = '0;
  logic [2:0]  sh_p = '0, sh_r = '0, seen_m = '0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, got, exp);
    end
  endfunction

  function automatic void decode(input logic [6:0] pat, output logic [3:0] n, output logic er);
    n = 4'h0;
    er = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (glyph[k] == pat) begin
        n = k[3:0];
        er = 1'b0;
      end
    end
  endfunction

  // Model one bus sample registered at edge j.
  function automatic void step(int j, logic r, logic [7:0] s, logic [2:0] e);
    int lows, idx;
    logic [3:0] n;
    logic er;
    ev_t ev;
    if (!r) begin
      while (eq.size() > 0 && eq[$].e >= j) void'(eq.pop_back());
      while (mq.size() > 0 && mq[$] >= j) void'(mq.pop_back());
      ev = '{j, 1'b1, 12'h000, 3'b000, 3'b000};
      eq.push_back(ev);
      dwell_on = 0; seen_m = '0; sh_d = '0; sh_p = '0; sh_r = '0;
      return;
    end
    lows = 0;
    idx = 0;
    for (int k = 0; k < 3; k++) begin
      if (!e[k]) begin
        lows++;
        idx = k;
      end
    end
    if (lows > 1) begin
      mq.push_back(j + 1);
      dwell_on = 0;
      return;
    end
    if (lows == 0) begin
      dwell_on = 0;
      return;
    end
    if (!dwell_on || e != dwell_en) begin
      dwell_on = 1; dwell_en = e; run_seg = s; run_len = 1; accepted = 0;
    end else if (s == run_seg) begin
      run_len++;
    end else begin
      run_seg = s;
      run_len = 1;
    end
    if (!accepted && run_len == S) begin
      accepted = 1;
      decode(~s[6:0], n, er);
      sh_d[idx*4 +: 4] = n;
      sh_p[idx] = ~s[7];
      sh_r[idx] = er;
      seen_m[idx] = 1'b1;
      if (seen_m == 3'b111) begin
        ev = '{j + 2, 1'b0, sh_d, sh_p, sh_r};
        eq.push_back(ev);
        seen_m = '0;
      end
    end
  endfunction

  // Monitor: pops expected events as their edge arrives and compares.
  bit          started = 0;
  int          base = 0;
  logic [17:0] held = '0;
  always @(negedge clk) begin
    int cur;
    bit exp_fv, exp_me, exp_st;
    cur = edge_cnt;
    exp_fv = 0;
    exp_me = 0;
    if (eq.size() > 0 && eq[0].e == cur) begin
      if (eq[0].is_rst) started = 1;
      else exp_fv = 1;
      held = {eq[0].d, eq[0].p, eq[0].r};
      base = cur;
      void'(eq.pop_front());
    end
    if (mq.size() > 0 && mq[0] == cur) begin
      exp_me = 1;
      void'(mq.pop_front());
    end
    if (started) begin
      exp_st = (cur - base) >= T;
      chk("FrameValid", 32'(fv), 32'(exp_fv));
      chk("MultiEnErr", 32'(mee), 32'(exp_me));
      chk("Stale", 32'(stale), 32'(exp_st));
      chk("Digits/Dp/DigitErr", 32'({digits, dp, derr}), 32'(held));
    end
  end

  task automatic cyc(input logic r, input logic [7:0] s, input logic [2:0] e);
    rst_n = r;
    seg = s;
    en = e;
    step(edge_cnt + 1, r, s, e);
    @(negedge clk);
  endtask

  function automatic logic [7:0] bus(int v, bit d);
    return {~d, ~glyph[v]};
  endfunction

  function automatic logic [2:0] dig_en(int dig);
    logic [2:0] one;
    one = 3'b001;
    return ~(one << dig);
  endfunction

  task automatic hold(int dig, logic [7:0] s, int n);
    for (int i = 0; i < n; i++) cyc(1'b1, s, dig_en(dig));
  endtask

  task automatic scan(logic [7:0] p2, logic [7:0] p1, logic [7:0] p0, int n);
    hold(0, p0, n);
    hold(1, p1, n);
    hold(2, p2, n);
  endtask

  initial begin
    logic [7:0] x, y, s;
    logic [2:0] e;
    int kind, len, gpos;

    for (int i = 0; i < 3; i++) cyc(1'b0, 8'hFF, 3'b111);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hFF, 3'b111);

    // Clean scan of "1A7"
    for (int i = 0; i < 3; i++) scan(bus(1, 0), bus(10, 0), bus(7, 0), 8);

    // Glitch on digit0
    x = bus($urandom_range(0, 15), 0);
    y = x ^ 8'h08;
    cyc(1'b1, x, 3'b110);
    cyc(1'b1, x, 3'b110);
    cyc(1'b1, y, 3'b110);
    hold(0, x, 8);
    hold(1, bus($urandom_range(0, 15), 1), 8);
    hold(2, bus($urandom_range(0, 15), 0), 8);

    // Illegal glyph on digit1 with dp lit
    scan(bus(3, 0), {1'b0, ~7'h49}, bus(12, 0), 8);

    // Ghosting: two enables low for one cycle mid-scan
    hold(0, bus(5, 0), 8);
    hold(1, bus(9, 0), 3);
    cyc(1'b1, 8'($urandom), 3'b100);
    hold(1, bus(9, 0), 5);
    hold(2, bus(14, 1), 8);
    scan(bus(2, 0), bus(11, 0), bus(6, 0), 8);

    // Timeout with the bus idle, then a clean scan
    for (int i = 0; i < 120; i++) cyc(1'b1, 8'hFF, 3'b111);
    scan(bus(1, 0), bus(10, 0), bus(7, 0), 8);

    // Reset mid-frame
    hold(0, bus(4, 0), 8);
    hold(1, bus(8, 0), 8);
    cyc(1'b0, bus(8, 0), 3'b101);
    hold(2, bus(15, 0), 8);
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'hFF, 3'b111);

    // Randomized dwells
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 9);
      len = $urandom_range(1, 10);
      e = 3'($urandom);
      if (kind >= 2) e = dig_en($urandom_range(0, 2));
      if (kind == 1) s = 8'($urandom);
      else s = bus($urandom_range(0, 15), 1'($urandom));
      gpos = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
      for (int k = 0; k < len; k++) cyc(1'b1, (k == gpos) ? 8'($urandom) : s, e);
    end

    for (int i = 0; i < 6; i++) cyc(1'b1, 8'hFF, 3'b111);
    #1;
    chk("pending frame events", 32'(eq.size()), 32'd0);
    chk("pending MultiEnErr events", 32'(mq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
